// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier for the multdiv unit.
// One add/subtract-and-shift step per cycle over a 2*WIDTH+1-bit product
// register {hi, lo, extra}. Returns the low WIDTH bits of the signed product
// plus an overflow flag, one cycle after the final RUN cycle.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int PW = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_product;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic [WIDTH:0]   w_hi;
  logic [WIDTH:0]   w_mcand;
  logic [WIDTH:0]   w_hiNext;
  logic [PW-1:0]    w_productNext;
  logic             w_exception;
  logic             w_lastStep;

  // Booth step datapath: hi +/- M at WIDTH+1 bits, then arithmetic shift right.
  // Bit 2*WIDTH is the guard/sign bit of hi, so it also sign-extends hi here.
  always_comb begin
    w_hi    = {r_product[PW-1], r_product[PW-1:WIDTH+1]};
    w_mcand = {r_mcand[WIDTH-1], r_mcand};
    case (r_product[1:0])
      2'b01:   w_hiNext = w_hi + w_mcand;
      2'b10:   w_hiNext = w_hi - w_mcand;
      default: w_hiNext = w_hi;
    endcase
    w_productNext = {w_hiNext, r_product[WIDTH:1]};
    w_exception   = !((&r_product[PW-1:WIDTH]) || (~|r_product[PW-1:WIDTH]));
    w_lastStep    = (r_count == CNT_W'(WIDTH));
  end

  // Control FSM plus product/count/output registers. A start pulse wins over
  // any state; the RUN cycle that finds count==WIDTH latches the outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_product   <= '0;
      r_mcand     <= '0;
      r_count     <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (ctrl_mult) begin
      r_state   <= S_RUN;
      r_mcand   <= data_operandA;
      r_product <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_count   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_lastStep) begin
            r_state     <= S_DONE;
            r_result    <= r_product[WIDTH:1];
            r_exception <= w_exception;
          end else begin
            r_product <= w_productNext;
            r_count   <= r_count + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq. Stimulus pushes the
// expected product (from plain signed arithmetic) and its due cycle; a monitor
// pops and compares whenever data_resultRDY is seen.
module tb_booth_mult_seq;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             exc;
    int               due;
  } exp_t;

  logic             clk;
  logic             clr;
  logic             ctrlMult;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] dataResult;
  logic             dataException;
  logic             dataResultRdy;
  logic             busy;

  exp_t sbQ[$];
  int   cycle;
  int   testsRun;
  int   testsFailed;

  booth_mult_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk            (clk),
    .clr            (clr),
    .ctrl_mult      (ctrlMult),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .data_result    (dataResult),
    .data_exception (dataException),
    .data_resultRDY (dataResultRdy),
    .busy           (busy)
  );

  // Free-running clock and rising-edge counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycle);
    end
  endtask

  // Reference model: full signed product, low half plus fit-in-WIDTH flag.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t   e;
    longint p;
    longint lowExt;
    p      = longint'($signed(a)) * longint'($signed(b));
    lowExt = longint'($signed(p[WIDTH-1:0]));
    e.res  = p[WIDTH-1:0];
    e.exc  = (p != lowExt);
    e.due  = 0;
    return e;
  endfunction

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dataResultRdy) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_rdy", 64'(dataResultRdy), 64'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("result", 64'(dataResult), 64'(e.res));
        checkOutput("exception", 64'(dataException), 64'(e.exc));
        checkOutput("rdy_cycle", 64'(cycle), 64'(e.due));
        checkOutput("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  // Start an operation, holding ctrl_mult for holdCycles edges; only the last
  // sampled start counts, and any in-flight expectation is abandoned.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int holdCycles);
    exp_t e;
    opA      = a;
    opB      = b;
    ctrlMult = 1'b1;
    sbQ.delete();
    repeat (holdCycles) @(posedge clk);
    #1;
    e     = model(a, b);
    e.due = cycle + LATENCY;
    sbQ.push_back(e);
    ctrlMult = 1'b0;
    opA      = $urandom;
    opB      = $urandom;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Wait until the scoreboard drains; an expired bound counts as a failure.
  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 3 * LATENCY) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput({name, "_timeout"}, 64'(sbQ.size()), 64'd0);
      sbQ.delete();
    end
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(a, b, 1);
    waitDone("op");
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_result"}, 64'(dataResult), 64'd0);
    checkOutput({tag, "_exception"}, 64'(dataException), 64'd0);
    checkOutput({tag, "_rdy"}, 64'(dataResultRdy), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Random operand source biased toward boundary values.
  function automatic logic [WIDTH-1:0] pickOperand();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'h7FFF_FFFF;
      2:       v = $urandom_range(0, 15);
      3:       v = -($urandom_range(0, 15));
      4:       v = $urandom & 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Directed scenarios followed by randomized operations.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clr         = 1'b1;
    ctrlMult    = 1'b0;
    opA         = '0;
    opB         = '0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");

    runOp(32'd3, 32'd4);
    runOp(32'hFFFF_FFF9, 32'd6);
    runOp(32'd6, 32'hFFFF_FFF9);
    runOp(32'h8000_0000, 32'hFFFF_FFFF);
    runOp(32'h8000_0000, 32'd1);
    runOp(32'h0001_0000, 32'h0001_0000);
    runOp(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    runOp(32'd0, 32'h1234_5678);

    // Restart mid-run: only the second operation may report.
    applyStimulus(32'd5, 32'd5, 1);
    repeat (9) @(posedge clk);
    #1;
    applyStimulus(32'd2, 32'd9, 1);
    waitDone("restart");

    // Clear mid-run: outputs return to zero and no pulse follows.
    applyStimulus(32'd5, 32'd5, 1);
    repeat (14) @(posedge clk);
    #1;
    clr = 1'b1;
    sbQ.delete();
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    checkIdleOutputs("clr_midrun");
    repeat (40) @(posedge clk);
    runOp(32'd5, 32'd5);

    // Start held high: no pulse while held, then the last start completes.
    applyStimulus(32'hFFFF_FFFD, 32'd11, 45);
    waitDone("held");

    // Start issued in the DONE cycle chains directly into a new run.
    applyStimulus(32'd7, 32'd8, 1);
    waitDone("chain_a");
    applyStimulus(32'hFFFF_0000, 32'h0000_8000, 1);
    waitDone("chain_b");

    for (int i = 0; i < 50; i++) begin
      runOp(pickOperand(), pickOperand());
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1);
  end

endmodule
